// File: rtl/stopwatch_pkg.sv
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and digit limits for the centisecond stopwatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t CSEC_MAX     = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

`default_nettype wire

// File: rtl/ms_stopwatch_bcd_digit.sv
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD counter digit, wraps at MAX and signals carry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = CSEC_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    bcd_t r_digit;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= (r_digit == MAX) ? '0 : r_digit + 4'd1;
        end
    end

    assign digit = r_digit;
    assign carry = inc & (r_digit == MAX);

endmodule

`default_nettype wire

// File: rtl/ms_stopwatch.sv
// ============================================================================
//  Module      : ms_stopwatch
//  Description : SS.cc BCD stopwatch clocked by edges of a sampled 1 kHz tick.
//                Optional lap hold built when MS_STOPWATCH_LAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        ovf,
    output logic        lap_hold
);

    localparam logic [7:0] c_presc_last = 8'(PRESCALE - 1);

    sw_state_t   r_state;
    logic [7:0]  r_presc;
    logic        r_tick_q;
    logic        r_ovf;
    logic        w_tick_rise;
    logic        w_csec_tick;
    logic [3:0]  w_inc;
    logic [3:0]  w_carry;
    bcd_t        w_digit [4];
    logic [15:0] w_live;

    assign w_tick_rise = tick_in & ~r_tick_q;
    assign w_csec_tick = (r_state == RUN) && w_tick_rise && (r_presc == c_presc_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_tick_q <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_tick_q <= tick_in;
            if (clear) begin
                r_state <= IDLE;
                r_presc <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_presc <= '0;
                        if (start_stop) r_state <= RUN;
                    end
                    RUN: begin
                        // A rise coinciding with the pause request is still counted.
                        if (w_tick_rise)
                            r_presc <= (r_presc == c_presc_last) ? '0 : r_presc + 8'd1;
                        if (start_stop) r_state <= PAUSE;
                    end
                    PAUSE: begin
                        if (start_stop) r_state <= RUN;
                    end
                    default: r_state <= IDLE;
                endcase
                if (w_carry[3]) r_ovf <= 1'b1;
            end
        end
    end

    assign w_inc[0] = w_csec_tick;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_digits
            bcd_digit #(
                .MAX ((i == 3) ? SEC_TENS_MAX : CSEC_MAX)
            ) u_digit (
                .clk   (clk),
                .reset (reset),
                .clr   (clear),
                .inc   (w_inc[i]),
                .digit (w_digit[i]),
                .carry (w_carry[i])
            );
            if (i < 3) begin : g_chain
                assign w_inc[i+1] = w_carry[i];
            end
        end
    endgenerate

    assign w_live  = {w_digit[3], w_digit[2], w_digit[1], w_digit[0]};
    assign running = (r_state == RUN);
    assign ovf     = r_ovf;

`ifdef MS_STOPWATCH_LAP_EN
    logic        r_lap_hold;
    logic [15:0] r_lap_cap;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_lap_hold <= 1'b0;
            r_lap_cap  <= '0;
        end else if (lap && (r_state != IDLE)) begin
            r_lap_hold <= ~r_lap_hold;
            if (!r_lap_hold) r_lap_cap <= w_live;
        end
    end

    assign lap_hold = r_lap_hold;
    assign bcd_out  = r_lap_hold ? r_lap_cap : w_live;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign lap_hold     = 1'b0;
    assign bcd_out      = w_live;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ms_stopwatch.sv
// ============================================================================
//  Module      : tb_ms_stopwatch
//  Description : Self-checking bench; two instances (PRESCALE 10 and 2) share
//                stimulus and are compared against an elapsed-time model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ms_stopwatch;

    logic        clk = 1'b0;
    logic        reset, tick_in, start_stop, clear, lap;
    logic [15:0] bcd0, bcd1;
    logic        run0, run1, ovf0, ovf1, lh0, lh1;

    always #5 clk = ~clk;

    ms_stopwatch #(.PRESCALE(10)) dut0 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .bcd_out(bcd0), .running(run0), .ovf(ovf0),
        .lap_hold(lh0)
    );

    ms_stopwatch #(.PRESCALE(2)) dut1 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .bcd_out(bcd1), .running(run1), .ovf(ovf1),
        .lap_hold(lh1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: elapsed time as an integer number of centiseconds.
    int presc [2] = '{10, 2};
    int m_t   [2];
    int m_edg [2];
    int m_mode[2];   // 0 idle, 1 run, 2 pause
    int m_cap [2];
    bit m_ovf [2];
    bit m_hold[2];
    bit m_tq;

    function automatic logic [15:0] to_bcd(input int t);
        return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit rise;
        int old_t;
        rise = tick_in && !m_tq;
        for (int k = 0; k < 2; k++) begin
            if (reset || clear) begin
                m_t[k] = 0; m_edg[k] = 0; m_mode[k] = 0;
                m_ovf[k] = 0; m_hold[k] = 0; m_cap[k] = 0;
            end else begin
                old_t = m_t[k];
                if (m_mode[k] == 1 && rise) begin
                    m_edg[k]++;
                    if (m_edg[k] == presc[k]) begin
                        m_edg[k] = 0;
                        m_t[k]++;
                        if (m_t[k] == 6000) begin
                            m_t[k]   = 0;
                            m_ovf[k] = 1;
                        end
                    end
                end
`ifdef MS_STOPWATCH_LAP_EN
                if (lap && m_mode[k] != 0) begin
                    if (!m_hold[k]) m_cap[k] = old_t;
                    m_hold[k] = !m_hold[k];
                end
`endif
                if (start_stop) m_mode[k] = (m_mode[k] == 1) ? 2 : 1;
            end
        end
        m_tq = reset ? 1'b0 : tick_in;
    endtask

    task automatic cyc(input bit r, input bit t, input bit s, input bit c, input bit l);
        reset = r; tick_in = t; start_stop = s; clear = c; lap = l;
        @(posedge clk);
        model_step();
        #1;
        chk("dut0.bcd_out",  32'(bcd0), 32'(m_hold[0] ? to_bcd(m_cap[0]) : to_bcd(m_t[0])));
        chk("dut0.running",  32'(run0), 32'(m_mode[0] == 1));
        chk("dut0.ovf",      32'(ovf0), 32'(m_ovf[0]));
        chk("dut0.lap_hold", 32'(lh0),  32'(m_hold[0]));
        chk("dut1.bcd_out",  32'(bcd1), 32'(m_hold[1] ? to_bcd(m_cap[1]) : to_bcd(m_t[1])));
        chk("dut1.running",  32'(run1), 32'(m_mode[1] == 1));
        chk("dut1.ovf",      32'(ovf1), 32'(m_ovf[1]));
        chk("dut1.lap_hold", 32'(lh1),  32'(m_hold[1]));
    endtask

    // n tick periods of 2*half clocks, tick high for the first half
    task automatic periods(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            repeat (half) cyc(0, 1, 0, 0, 0);
            repeat (half) cyc(0, 0, 0, 0, 0);
        end
    endtask

    typedef struct {
        bit          r, t, s, c, l;
        logic [15:0] bcd;
        bit          run;
        bit          ovf;
    } vec_t;

    vec_t tbl [14];

    initial begin
        m_tq = 0;
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_edg[k] = 0; m_mode[k] = 0;
            m_cap[k] = 0; m_ovf[k] = 0; m_hold[k] = 0;
        end

        //            r  t  s  c  l   bcd       run ovf
        tbl[0]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 16'h0000, 0, 0};  // tick in idle
        tbl[2]  = '{0, 0, 0, 0, 0, 16'h0000, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 16'h0000, 1, 0};  // rise with entering start not counted
        tbl[4]  = '{0, 0, 0, 0, 0, 16'h0000, 1, 0};
        tbl[5]  = '{0, 0, 1, 1, 0, 16'h0000, 0, 0};  // clear beats start_stop
        tbl[6]  = '{0, 0, 0, 0, 0, 16'h0000, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 16'h0000, 1, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 16'h0000, 0, 0};  // pause
        tbl[9]  = '{0, 1, 0, 0, 0, 16'h0000, 0, 0};  // rise in pause ignored
        tbl[10] = '{0, 0, 0, 0, 0, 16'h0000, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 0, 16'h0000, 1, 0};  // resume
        tbl[12] = '{0, 0, 0, 1, 0, 16'h0000, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 1, 16'h0000, 0, 0};  // lap in idle ignored

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].c, tbl[i].l);
            chk($sformatf("tbl%0d.bcd", i), 32'(bcd0), 32'(tbl[i].bcd));
            chk($sformatf("tbl%0d.run", i), 32'(run0), 32'(tbl[i].run));
            chk($sformatf("tbl%0d.ovf", i), 32'(ovf0), 32'(tbl[i].ovf));
        end

        // Basic counting with the divider output (period 10 clk)
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        periods(10, 5);
        chk("count_100clk", 32'(bcd0), 32'h0001);
        periods(990, 5);
        chk("count_10000clk", 32'(bcd0), 32'h0100);
        chk("count_running", 32'(run0), 32'h1);

        // Pause preserves the prescaler phase
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        periods(53, 5);
        chk("pre_pause", 32'(bcd0), 32'h0005);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 50; i++) begin
            periods(1, 5);
            chk("during_pause", 32'(bcd0), 32'h0005);
        end
        cyc(0, 0, 1, 0, 0);
        periods(6, 5);
        chk("resume_6_edges", 32'(bcd0), 32'h0005);
        periods(1, 5);
        chk("resume_7_edges", 32'(bcd0), 32'h0006);

        // Wrap 59.99 -> 00.00 on the PRESCALE=2 instance
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        periods(5999 * 2, 1);
        chk("at_5999", 32'(bcd1), 32'h5999);
        chk("ovf_before_wrap", 32'(ovf1), 32'h0);
        periods(2, 1);
        chk("wrap_bcd", 32'(bcd1), 32'h0000);
        chk("wrap_ovf", 32'(ovf1), 32'h1);
        periods(20, 1);
        chk("after_wrap_bcd", 32'(bcd1), 32'h0010);
        chk("ovf_sticky", 32'(ovf1), 32'h1);
        cyc(0, 0, 0, 1, 0);
        chk("ovf_cleared", 32'(ovf1), 32'h0);

        // Reset in mid-count, then ticks without start
        cyc(0, 0, 1, 0, 0);
        periods(1234 * 2, 1);
        chk("at_1234", 32'(bcd1), 32'h1234);
        cyc(1, 0, 0, 0, 0);
        chk("rst_bcd", 32'(bcd1), 32'h0000);
        chk("rst_running", 32'(run1), 32'h0);
        chk("rst_ovf", 32'(ovf1), 32'h0);
        chk("rst_lap_hold", 32'(lh1), 32'h0);
        periods(3, 1);
        chk("ticks_no_start", 32'(bcd1), 32'h0000);

        // Lap hold
        cyc(0, 0, 1, 0, 0);
        periods(321 * 2, 1);
        chk("lap_pre", 32'(bcd1), 32'h0321);
        cyc(0, 0, 0, 0, 1);
        chk("lap_capture", 32'(bcd1), 32'h0321);
`ifdef MS_STOPWATCH_LAP_EN
        chk("lap_hold_set", 32'(lh1), 32'h1);
        periods(79 * 2, 1);
        chk("lap_frozen", 32'(bcd1), 32'h0321);
        cyc(0, 0, 0, 0, 1);
        chk("lap_release", 32'(bcd1), 32'h0400);
        chk("lap_hold_clr", 32'(lh1), 32'h0);
`else
        chk("lap_ignored", 32'(lh1), 32'h0);
        periods(79 * 2, 1);
        chk("lap_no_freeze", 32'(bcd1), 32'h0400);
`endif

        // Random stimulus against the model
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0,
                $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
